exec_unit: RTL and testbench



---
 rtl/exec_unit.sv | 175 +++++++++++++++++
 tb/tb_exec_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Execute/writeback stage feeding the register file: single-cycle ALU ops plus
// bit-serial shifts and shift-add multiply under a busy handshake.
module exec_unit #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [3:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [AW-1:0] dst,
    input  logic          wb_en,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] di,
    output logic          we,
    output logic [AW-1:0] ptr_w,
    output logic          r_overflow
);

    localparam int CW = $clog2(DW + 1);

    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_dst;
    logic            r_wbEn;
    logic            r_shLeft;
    logic [DW-1:0]   r_shval;
    logic [2*DW-1:0] r_acc;
    logic [2*DW-1:0] r_mcand;
    logic [DW-1:0]   r_mplier;

    logic [2:0]      w_k;
    logic            w_isShift;
    logic            w_isMul;
    logic            w_multi;
    logic [DW:0]     w_sum;
    logic [DW-1:0]   w_res;
    logic            w_flag;
    logic [DW-1:0]   w_shNext;
    logic            w_shOut;
    logic [2*DW-1:0] w_accNext;

    assign w_k       = b[2:0];
    assign w_isShift = (op == OP_SHL) || (op == OP_SHR);
    assign w_isMul   = (op == OP_MUL);
    assign w_multi   = w_isMul || (w_isShift && (w_k != 3'd0));
    assign w_shNext  = r_shLeft ? (r_shval << 1) : (r_shval >> 1);
    assign w_shOut   = r_shLeft ? r_shval[DW-1] : r_shval[0];
    assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Single-cycle result; a zero-count shift passes a through and clears the flag.
    always_comb begin
        w_sum  = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, (op == OP_ADC) ? r_overflow : 1'b0};
        w_res  = di;
        w_flag = r_overflow;
        case (op)
            OP_MOV:         w_res = b;
            OP_ADD, OP_ADC: begin w_res = w_sum[DW-1:0]; w_flag = w_sum[DW]; end
            OP_SUB:         begin w_res = a - b; w_flag = (a < b); end
            OP_AND:         w_res = a & b;
            OP_OR:          w_res = a | b;
            OP_XOR:         w_res = a ^ b;
            OP_SHL, OP_SHR: begin w_res = a; w_flag = 1'b0; end
            default:        ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start && w_multi) w_next = w_isMul ? MUL : SHIFT;
            SHIFT,
            MUL:     if (r_count == CW'(1)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
    end

    // Datapath: operands are latched at acceptance, results land with the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            done       <= 1'b0;
            we         <= 1'b0;
            di         <= '0;
            ptr_w      <= '0;
            r_overflow <= 1'b0;
            r_count    <= '0;
            r_dst      <= '0;
            r_wbEn     <= 1'b0;
            r_shLeft   <= 1'b0;
            r_shval    <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
        end else begin
            done <= 1'b0;
            we   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dst  <= dst;
                        r_wbEn <= wb_en;
                        if (w_isMul) begin
                            r_acc    <= '0;
                            r_mcand  <= {{DW{1'b0}}, a};
                            r_mplier <= b;
                            r_count  <= CW'(DW);
                        end else if (w_multi) begin
                            r_shval  <= a;
                            r_shLeft <= (op == OP_SHL);
                            r_count  <= CW'(w_k);
                        end else begin
                            di         <= w_res;
                            ptr_w      <= dst;
                            r_overflow <= w_flag;
                            done       <= 1'b1;
                            we         <= wb_en && (op < 4'd10);
                        end
                    end
                end
                SHIFT: begin
                    r_shval <= w_shNext;
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        di         <= w_shNext;
                        ptr_w      <= r_dst;
                        r_overflow <= w_shOut;
                        done       <= 1'b1;
                        we         <= r_wbEn;
                    end
                end
                MUL: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        di         <= w_accNext[DW-1:0];
                        ptr_w      <= r_dst;
                        r_overflow <= |w_accNext[2*DW-1:DW];
                        done       <= 1'b1;
                        we         <= r_wbEn;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit: hand-computed vectors covering
// ALU ops, flag rules, iterated shift/multiply latency, handshake and reset abort.
module tb_exec_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] dst;
    logic       wb_en;
    logic       busy;
    logic       done;
    logic [7:0] di;
    logic       we;
    logic [4:0] ptr_w;
    logic       r_overflow;

    int vectors     = 0;
    int miscompares = 0;

    exec_unit #(.DW(8), .AW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .dst        (dst),
        .wb_en      (wb_en),
        .busy       (busy),
        .done       (done),
        .di         (di),
        .we         (we),
        .ptr_w      (ptr_w),
        .r_overflow (r_overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one issue strobe; returns #1 after the accepting edge (cycle 1).
    task automatic applyStimulus(input logic [3:0] iOp, input logic [7:0] iA, input logic [7:0] iB,
                                 input logic [4:0] iDst, input logic iWb);
        op    = iOp;
        a     = iA;
        b     = iB;
        dst   = iDst;
        wb_en = iWb;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int lat;
        int pulses;
        reset = 1'b1; start = 1'b0; op = 4'd0; a = 8'd0; b = 8'd0; dst = 5'd0; wb_en = 1'b0;
        step();
        step();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_we", we, 0);
        checkOutput("rst_di", di, 0);
        checkOutput("rst_ptr", ptr_w, 0);
        checkOutput("rst_ovf", r_overflow, 0);
        reset = 1'b0;
        step();

        applyStimulus(4'd1, 8'd200, 8'd100, 5'd3, 1'b1);
        checkOutput("add_done", done, 1);
        checkOutput("add_we", we, 1);
        checkOutput("add_di", di, 44);
        checkOutput("add_ptr", ptr_w, 3);
        checkOutput("add_ovf", r_overflow, 1);

        applyStimulus(4'd3, 8'd5, 8'd7, 5'd4, 1'b1);
        checkOutput("sub_done", done, 1);
        checkOutput("sub_di", di, 254);
        checkOutput("sub_ptr", ptr_w, 4);
        checkOutput("sub_ovf", r_overflow, 1);

        applyStimulus(4'd2, 8'd255, 8'd0, 5'd5, 1'b1);
        checkOutput("adc_di", di, 0);
        checkOutput("adc_ovf", r_overflow, 1);

        applyStimulus(4'd4, 8'hF0, 8'h3C, 5'd6, 1'b1);
        checkOutput("and_di", di, 8'h30);
        checkOutput("and_ovf", r_overflow, 1);
        step();
        checkOutput("idle_done", done, 0);
        checkOutput("idle_we", we, 0);
        checkOutput("idle_di_hold", di, 8'h30);

        applyStimulus(4'd7, 8'h81, 8'd3, 5'd7, 1'b1);
        a = 8'h00; b = 8'h07; op = 4'd0;
        for (int c = 1; c <= 3; c++) begin
            checkOutput($sformatf("shl_busy_c%0d", c), {busy, done}, 2'b10);
            step();
        end
        checkOutput("shl_done", done, 1);
        checkOutput("shl_busy_done", busy, 0);
        checkOutput("shl_we", we, 1);
        checkOutput("shl_di", di, 8'h08);
        checkOutput("shl_ptr", ptr_w, 7);
        checkOutput("shl_ovf", r_overflow, 0);

        applyStimulus(4'd8, 8'h81, 8'd1, 5'd8, 1'b1);
        checkOutput("shr_busy", {busy, done}, 2'b10);
        step();
        checkOutput("shr_done", done, 1);
        checkOutput("shr_di", di, 8'h40);
        checkOutput("shr_ovf", r_overflow, 1);

        applyStimulus(4'd7, 8'h5A, 8'd0, 5'd9, 1'b1);
        checkOutput("shl0_done", done, 1);
        checkOutput("shl0_busy", busy, 0);
        checkOutput("shl0_di", di, 8'h5A);
        checkOutput("shl0_ovf", r_overflow, 0);

        applyStimulus(4'd9, 8'd20, 8'd15, 5'd9, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            checkOutput($sformatf("mul_busy_c%0d", c), {busy, done}, 2'b10);
            if (c == 3) begin
                start = 1'b1; op = 4'd1; a = 8'd1; b = 8'd1; dst = 5'd1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        checkOutput("mul_done", done, 1);
        checkOutput("mul_busy_done", busy, 0);
        checkOutput("mul_we", we, 1);
        checkOutput("mul_di", di, 44);
        checkOutput("mul_ptr", ptr_w, 9);
        checkOutput("mul_ovf", r_overflow, 1);
        step();
        checkOutput("mul_single_pulse", done, 0);

        applyStimulus(4'd9, 8'd12, 8'd10, 5'd10, 1'b1);
        lat = 1;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        checkOutput("mul2_latency", lat, 9);
        checkOutput("mul2_di", di, 120);
        checkOutput("mul2_ovf", r_overflow, 0);

        applyStimulus(4'd1, 8'd200, 8'd100, 5'd3, 1'b1);
        checkOutput("pre_abort_ovf", r_overflow, 1);
        applyStimulus(4'd9, 8'd20, 8'd15, 5'd11, 1'b1);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ovf", r_overflow, 0);
        checkOutput("abort_done_we", {done, we}, 2'b00);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (done || we) pulses++;
        end
        checkOutput("abort_no_done", pulses, 0);

        applyStimulus(4'd1, 8'd1, 8'd1, 5'd12, 1'b0);
        checkOutput("nowb_done", done, 1);
        checkOutput("nowb_we", we, 0);
        checkOutput("nowb_di", di, 2);
        checkOutput("nowb_ovf", r_overflow, 0);

        applyStimulus(4'd3, 8'd0, 8'd1, 5'd13, 1'b1);
        checkOutput("sub0_di", di, 255);
        checkOutput("sub0_ovf", r_overflow, 1);

        applyStimulus(4'd12, 8'd3, 8'd4, 5'd14, 1'b1);
        checkOutput("nop_done", done, 1);
        checkOutput("nop_we", we, 0);
        checkOutput("nop_ovf", r_overflow, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
